// File: rtl/rv32_instr_mem.sv
// Instruction-memory responder: synchronous SRAM model with optional wait states,
// combinational address-match qualification of ready, and a loader write port.
module rv32_instr_mem #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_bus,
  output logic        instr_ready,
  output logic        instr_err,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] DEPTH    = 32'(MEM_WORDS);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  function automatic logic word_in_range(input logic [31:0] addr);
    return ({2'b00, addr[31:2]} < DEPTH);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]   req_addr_q, req_addr_d;
  logic          req_valid_q, req_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;

  logic          restart_s;
  logic [31:0]   load_addr_s;
  logic          load_err_s;
  logic [31:0]   load_data_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] ld_idx_s;
  logic          unused_ld_lsb_s;

  assign ld_idx_s        = ld_addr[AW+1:2];
  assign unused_ld_lsb_s = ^ld_addr[1:0];

  // Restart decision and the word a load would fetch this cycle, with write-first forwarding.
  always_comb begin
    restart_s   = !req_valid_q || (instr_addr != req_addr_q) ||
                  (ld_we && (ld_addr[31:2] == req_addr_q[31:2]));
    load_addr_s = restart_s ? instr_addr : req_addr_q;
    rd_idx_s    = load_addr_s[AW+1:2];
    load_err_s  = (load_addr_s[1:0] != 2'b00) || !word_in_range(load_addr_s);
    if (load_err_s) begin
      load_data_s = NOP;
    end else if (ld_we && (ld_addr[31:2] == load_addr_s[31:2])) begin
      load_data_s = ld_data;
    end else begin
      load_data_s = mem[rd_idx_s];
    end
  end

  // Request tracking: restart, count down wait states, or hold.
  always_comb begin
    req_addr_d  = req_addr_q;
    req_valid_d = req_valid_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    data_d      = data_q;
    err_d       = err_q;
    if (restart_s) begin
      req_addr_d  = instr_addr;
      req_valid_d = 1'b1;
      cnt_d       = CNT_INIT;
      if (WAIT_CYCLES == 0) begin
        data_d  = load_data_s;
        err_d   = load_err_s;
        ready_d = 1'b1;
      end else begin
        ready_d = 1'b0;
      end
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
        data_d  = load_data_s;
        err_d   = load_err_s;
        ready_d = 1'b1;
      end else begin
        ready_d = ready_q;
      end
    end else begin
      ready_d = ready_q;
    end
  end

  // Request state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_q  <= 32'h0000_0000;
      req_valid_q <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      ready_q     <= 1'b0;
      data_q      <= NOP;
      err_q       <= 1'b0;
    end else begin
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Loader writes; the array itself is never reset and out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (ld_we && word_in_range(ld_addr)) begin
      mem[ld_idx_s] <= ld_data;
    end
  end

  assign instr_ready = ready_q & (instr_addr == req_addr_q);
  assign instr_bus   = data_q;
  assign instr_err   = err_q & instr_ready;

endmodule

// File: tb/tb_rv32_instr_mem.sv
// Directed bench for rv32_instr_mem: one zero-wait instance and one three-wait instance
// sharing clock, reset and loader port.
module tb_rv32_instr_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  logic [31:0] addr0 = 32'h0;
  logic [31:0] addr3 = 32'h0;
  logic [31:0] bus0, bus3;
  logic        rdy0, rdy3, err0, err3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_instr_mem #(.MEM_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .instr_addr(addr0), .instr_bus(bus0),
    .instr_ready(rdy0), .instr_err(err0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  rv32_instr_mem #(.MEM_WORDS(64), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .instr_addr(addr3), .instr_bus(bus3),
    .instr_ready(rdy3), .instr_err(err3),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  initial begin
    // Fill memory while reset is held; the array is not reset.
    load(32'h00, 32'h0050_0093);
    load(32'h04, 32'h0010_0113);
    load(32'h08, 32'h0020_81B3);
    load(32'h0C, 32'h0000_006F);
    load(32'h10, 32'hAAAA_0004);
    load(32'h20, 32'hBBBB_0008);
    chk("rst_rdy0", {31'b0, rdy0}, 32'd0);
    chk("rst_err0", {31'b0, err0}, 32'd0);
    chk("rst_bus0", bus0, 32'h0000_0013);
    chk("rst_rdy3", {31'b0, rdy3}, 32'd0);

    // Sequential fetch on dut0, wait-state hold on dut3.
    addr0 = 32'h00; addr3 = 32'h10; reset = 1'b0; #1;
    chk("idle_rdy0", {31'b0, rdy0}, 32'd0);
    step();
    chk("seq0_rdy", {31'b0, rdy0}, 32'd1);
    chk("seq0_bus", bus0, 32'h0050_0093);
    chk("w3_c1", {31'b0, rdy3}, 32'd0);
    addr0 = 32'h04; #1;
    chk("seq_drop", {31'b0, rdy0}, 32'd0);
    step();
    chk("seq1_bus", bus0, 32'h0010_0113);
    chk("seq1_rdy", {31'b0, rdy0}, 32'd1);
    chk("w3_c2", {31'b0, rdy3}, 32'd0);
    addr0 = 32'h08;
    step();
    chk("seq2_bus", bus0, 32'h0020_81B3);
    chk("w3_c3", {31'b0, rdy3}, 32'd0);
    addr0 = 32'h0C;
    step();
    chk("seq3_bus", bus0, 32'h0000_006F);
    chk("w3_c4_rdy", {31'b0, rdy3}, 32'd1);
    chk("w3_c4_bus", bus3, 32'hAAAA_0004);
    step(); step();
    chk("w3_hold_rdy", {31'b0, rdy3}, 32'd1);
    chk("w3_hold_bus", bus3, 32'hAAAA_0004);

    // Abort mid-wait: 0x10 for two cycles, then 0x20.
    addr3 = 32'h00; step();
    addr3 = 32'h10; step(); step();
    chk("abort_pre", {31'b0, rdy3}, 32'd0);
    addr3 = 32'h20; #1;
    chk("abort_sw", {31'b0, rdy3}, 32'd0);
    step(); chk("abort_c1", {31'b0, rdy3}, 32'd0);
    step(); chk("abort_c2", {31'b0, rdy3}, 32'd0);
    step(); chk("abort_c3", {31'b0, rdy3}, 32'd0);
    step();
    chk("abort_c4_rdy", {31'b0, rdy3}, 32'd1);
    chk("abort_c4_bus", bus3, 32'hBBBB_0008);

    // Error requests: misaligned and out of range.
    addr0 = 32'h02; addr3 = 32'h02; step();
    chk("mis_rdy", {31'b0, rdy0}, 32'd1);
    chk("mis_err", {31'b0, err0}, 32'd1);
    chk("mis_bus", bus0, 32'h0000_0013);
    chk("mis3_err_c1", {31'b0, err3}, 32'd0);
    addr0 = 32'h100; step();
    chk("oor_rdy", {31'b0, rdy0}, 32'd1);
    chk("oor_err", {31'b0, err0}, 32'd1);
    chk("oor_bus", bus0, 32'h0000_0013);
    step(); step();
    chk("mis3_rdy", {31'b0, rdy3}, 32'd1);
    chk("mis3_err", {31'b0, err3}, 32'd1);
    load(32'h100, 32'hDEAD_BEEF);
    addr0 = 32'h00; step();
    chk("oor_wr_bus", bus0, 32'h0050_0093);
    chk("oor_wr_err", {31'b0, err0}, 32'd0);

    // Loader write hit with zero wait states.
    addr0 = 32'h08;
    load(32'h08, 32'h1111_1111);
    chk("hit_pre_bus", bus0, 32'h1111_1111);
    ld_we = 1'b1; ld_addr = 32'h08; ld_data = 32'h2222_2222; #1;
    chk("hit_gap", {31'b0, rdy0}, 32'd1);
    step();
    ld_we = 1'b0;
    chk("hit_rdy", {31'b0, rdy0}, 32'd1);
    chk("hit_bus", bus0, 32'h2222_2222);

    // Asynchronous reset mid-wait on dut3 and mid-ready on dut0.
    addr3 = 32'h10; step(); step();
    #2 reset = 1'b1; #1;
    chk("arst_rdy3", {31'b0, rdy3}, 32'd0);
    chk("arst_err3", {31'b0, err3}, 32'd0);
    chk("arst_rdy0", {31'b0, rdy0}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rel_rdy0", {31'b0, rdy0}, 32'd1);
    chk("rel_bus0", bus0, 32'h2222_2222);
    chk("rel3_c1", {31'b0, rdy3}, 32'd0);
    step(); step();
    chk("rel3_c3", {31'b0, rdy3}, 32'd0);
    step();
    chk("rel3_c4_rdy", {31'b0, rdy3}, 32'd1);
    chk("rel3_c4_bus", bus3, 32'hAAAA_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
